spi_dac_slave_rx: RTL and testbench
===================================

Name: spi_dac_slave_rx

Overview:
- SPI responder for the DAC link: receives the 16-bit DAC word that the design's SPI master sends as two bytes (MSB byte first) in one CS_n-low frame.
- Runs as a DAC stand-in on the bench and as a loopback monitor on the PCB header. The loopback lets firmware check DAC_val end to end.
- Oversamples the SPI pins on the system clock, assembles the frame and presents each completed word with a one-cycle valid strobe.
- Malformed frames are flagged and discarded.

Parameters:
- FRAME_BITS, 16, bits per CS_n-low frame; frames of any other length are errors.
- SYNC_STAGES, 2, synchronizer flops on each SPI input (minimum 2).
- CPOL, 0, idle SCLK level; must match the master.
- CPHA, 0, 0 = sample MOSI on the leading SCLK edge, 1 = on the trailing edge.

Ports:
- i_Clk  in  1  system clock (CLOCK_50 domain); SCLK must be ≤ i_Clk/4.
- i_Rst  in  1  synchronous reset, active-high.
- i_SPI_Clk  in  1  SPI clock from the master, asynchronous.
- i_SPI_MOSI  in  1  SPI data, MSB first, asynchronous.
- i_SPI_CS_n  in  1  chip select, active-low, asynchronous.
- o_RX_Word  out  FRAME_BITS  last good word; held until the next good frame.
- o_RX_DV  out  1  one-cycle strobe when o_RX_Word updates.
- o_Frame_Err  out  1  one-cycle strobe on a short or long frame.
- o_Busy  out  1  high while a frame is in progress (state SHIFT).
- o_Err_Count  out  8  saturating count of frame errors.

Behaviour:
- Interface: one clock (i_Clk); reset is synchronous and active-high (i_Rst).
- Reset values: o_RX_Word=0, o_RX_DV=0, o_Frame_Err=0, o_Busy=0, o_Err_Count=0, bit counter=0, shift register=0, state=IDLE. Synchronizer flops reset to the idle levels: SCLK=CPOL, CS_n=1, MOSI=0.
- Input conditioning:
  - Each input passes through SYNC_STAGES flops, plus one history flop for edge detection.
  - Derived single-cycle events: sample_edge (selected by CPOL/CPHA), cs_fall, cs_rise.
- State machine:
  - IDLE: on cs_fall → SHIFT; clear bit counter and shift register.
  - SHIFT, on sample_edge:
    - shift_reg <= {shift_reg[FRAME_BITS-2:0], mosi_sync}.
    - bit_cnt increments and saturates at FRAME_BITS+1. The extra count value marks an overrun; bits after the 16th are not shifted in.
  - SHIFT, on cs_rise → DONE.
  - DONE (one cycle):
    - If bit_cnt==FRAME_BITS: o_RX_Word<=shift_reg and o_RX_DV=1.
    - Otherwise: o_Frame_Err=1 and o_Err_Count increments (saturating at 255); o_RX_Word is unchanged.
    - Then → IDLE.
- Latency: o_RX_DV asserts exactly SYNC_STAGES+2 i_Clk cycles after the first i_Clk edge that samples i_SPI_CS_n high.
- Simultaneous events:
  - sample_edge and cs_rise in the same cycle: the edge is counted first, then the frame closes.
  - cs_fall while in DONE: the DONE action completes and the new frame is ignored until the next cs_fall. The master guarantees ≥2 SCLK periods of CS_n high, so this never happens in normal operation.
- CS_n held low with no SCLK: stay in SHIFT indefinitely; no timeout.
- Zero-bit frame (CS_n pulse with no clocks): counts as an error.
- Reset mid-frame: return to IDLE immediately; the partial frame is dropped without an error. A frame whose CS_n was already low when reset released is ignored until the next cs_fall.
- Widths: bit_cnt is clog2(FRAME_BITS+2) bits. o_Err_Count saturates at 255 and never wraps.

Decomposition:
- Shared package spi_dac_pkg:
  - FRAME_BITS_DEFAULT=16.
  - State encoding: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - ERR_CNT_W=8.
- Sub-module spi_pin_sync: a SYNC_STAGES synchronizer plus history flop per pin. Outputs the synced levels and the rise/fall strobes. It is reused by the future I2C receiver-side monitor.

Test Plan:
- Mode 0, SCLK=i_Clk/8, master sends 0x9E then 0x23 in one CS_n frame → exactly one o_RX_DV; o_RX_Word=16'h9E23 at SYNC_STAGES+2 cycles after CS_n rise; o_Frame_Err never asserts.
- Back-to-back frames 0xFFFF, 0x0000, 0x8001 with minimum CS_n-high gap → three strobes carrying those values in order; o_Err_Count=0.
- Short frame of 15 clocks, then long frame of 17 clocks, then a good 0x1234 → two o_Frame_Err pulses; o_RX_Word stays 0 until the good frame makes it 0x1234; o_Err_Count=2.
- Assert i_Rst for 1 cycle after 8 bits of a frame → o_Busy=0 next cycle; no DV or error for that frame; next full frame 0xA5A5 is received correctly.
- Issue 300 CS_n pulses with no SCLK → o_Err_Count saturates at 255; o_RX_Word unchanged.
- CPHA=1 build, frame 0x5AC3 → o_RX_Word=0x5AC3; a mode-0 stimulus of the same pattern in this build yields a mis-sampled word with no error flagged, which documents that the mode must match the master.

Source files
------------

// File: rtl/spi_dac_pkg.sv
// spi_dac_pkg: shared widths and state encoding for the SPI DAC receiver.
package spi_dac_pkg;
    localparam int FRAME_BITS_DEFAULT = 16;
    localparam int ERR_CNT_W = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: multi-flop synchronizer with history flop and registered edge strobes.
module spi_pin_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic hist_q, hist_d, rise_q, rise_d, fall_q, fall_d;
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_pin};
        hist_d = sync_q[SYNC_STAGES-1];
        rise_d = hist_d & ~hist_q;
        fall_d = ~hist_d & hist_q;
    end
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            hist_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end
    assign o_level = hist_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;
endmodule

// File: rtl/spi_dac_slave_rx.sv
// spi_dac_slave_rx: oversampling SPI responder that captures one FRAME_BITS word per CS_n frame.
module spi_dac_slave_rx
    import spi_dac_pkg::*;
#(
    parameter int FRAME_BITS  = FRAME_BITS_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_SPI_Clk,
    input  logic                  i_SPI_MOSI,
    input  logic                  i_SPI_CS_n,
    output logic [FRAME_BITS-1:0] o_RX_Word,
    output logic                  o_RX_DV,
    output logic                  o_Frame_Err,
    output logic                  o_Busy,
    output logic [ERR_CNT_W-1:0]  o_Err_Count
);
    localparam int CW = $clog2(FRAME_BITS + 2);
    localparam logic [CW-1:0] FULL = CW'(FRAME_BITS);
    localparam logic [CW-1:0] OVR  = CW'(FRAME_BITS + 1);
    localparam int SW = $clog2(SYNC_STAGES + 3);
    localparam logic [SW-1:0] SETTLE = SW'(SYNC_STAGES + 2);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_sync, mosi_rise, mosi_fall;
    logic sample_edge, armed, good;
    logic unused_pins;
    state_t state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d, rx_word_q, rx_word_d;
    logic rx_dv_q, rx_dv_d, frame_err_q, frame_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'(CPOL))) u_sclk (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_pin(i_SPI_Clk),
        .o_level(sclk_level), .o_rise(sclk_rise), .o_fall(sclk_fall));
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_pin(i_SPI_CS_n),
        .o_level(cs_level), .o_rise(cs_rise), .o_fall(cs_fall));
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_pin(i_SPI_MOSI),
        .o_level(mosi_sync), .o_rise(mosi_rise), .o_fall(mosi_fall));

    assign unused_pins = ^{sclk_level, cs_level, mosi_rise, mosi_fall};
    assign sample_edge = (CPOL != CPHA) ? sclk_fall : sclk_rise;
    // A CS_n already low at reset release shows up as a fake fall while the pipeline refills.
    assign armed = settle_q == SETTLE;
    assign settle_d = armed ? settle_q : settle_q + 1'b1;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = (cs_fall && armed) ? SHIFT : IDLE;
            SHIFT:   state_d = cs_rise ? DONE : SHIFT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_word_d   = rx_word_q;
        rx_dv_d     = 1'b0;
        frame_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        good        = bit_cnt_q == FULL;
        if (state_q == IDLE && cs_fall && armed) begin
            bit_cnt_d = '0;
            shift_d   = '0;
        end
        if (state_q == SHIFT && sample_edge && bit_cnt_q != OVR) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = (bit_cnt_q != FULL) ? {shift_q[FRAME_BITS-2:0], mosi_sync} : shift_q;
        end
        if (state_q == DONE) begin
            rx_word_d   = good ? shift_q : rx_word_q;
            rx_dv_d     = good;
            frame_err_d = !good;
            err_cnt_d   = (good || &err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q     <= IDLE;
            settle_q    <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_word_q   <= '0;
            rx_dv_q     <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_word_q   <= rx_word_d;
            rx_dv_q     <= rx_dv_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign o_RX_Word   = rx_word_q;
    assign o_RX_DV     = rx_dv_q;
    assign o_Frame_Err = frame_err_q;
    assign o_Busy      = state_q == SHIFT;
    assign o_Err_Count = err_cnt_q;
endmodule

// File: tb/tb_spi_dac_slave_rx.sv
// tb_spi_dac_slave_rx: directed frames against mode-0 and CPHA=1 builds with hand-computed expectations.
module tb_spi_dac_slave_rx;
    logic clk = 1'b0, rst, sclk, mosi, cs_n;
    logic [15:0] word0, word1;
    logic dv0, dv1, err0, err1, busy0, busy1;
    logic [7:0] ecnt0, ecnt1;
    int cyc = 0, t_cs = 0, last_dv_cyc = 0;
    int dv0_cnt = 0, err0_cnt = 0, dv1_cnt = 0, err1_cnt = 0;
    int vectors = 0, miscompares = 0, dv1_base, err1_base;
    logic [15:0] words[$];

    spi_dac_slave_rx dut0 (
        .i_Clk(clk), .i_Rst(rst), .i_SPI_Clk(sclk), .i_SPI_MOSI(mosi), .i_SPI_CS_n(cs_n),
        .o_RX_Word(word0), .o_RX_DV(dv0), .o_Frame_Err(err0), .o_Busy(busy0), .o_Err_Count(ecnt0));
    spi_dac_slave_rx #(.CPHA(1)) dut1 (
        .i_Clk(clk), .i_Rst(rst), .i_SPI_Clk(sclk), .i_SPI_MOSI(mosi), .i_SPI_CS_n(cs_n),
        .o_RX_Word(word1), .o_RX_DV(dv1), .o_Frame_Err(err1), .o_Busy(busy1), .o_Err_Count(ecnt1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (dv0) begin
            dv0_cnt <= dv0_cnt + 1;
            words.push_back(word0);
            last_dv_cyc <= cyc;
        end
        if (err0) err0_cnt <= err0_cnt + 1;
        if (dv1) dv1_cnt <= dv1_cnt + 1;
        if (err1) err1_cnt <= err1_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode-0 master, SCLK = clk/8; bits past 16 are sent as 0; rst_at >= 0 pulses reset before that bit
    task automatic send0(input logic [15:0] w, input int nbits, input int rst_at);
        cs_n = 1'b0;
        tick(4);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                check("busy_before_rst", busy0, 1);
                rst = 1'b1;
                tick(1);
                check("busy_after_rst", busy0, 0);
                rst = 1'b0;
            end
            mosi = (i < 16) ? w[15-i] : 1'b0;
            tick(4);
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
        end
        mosi = 1'b0;
        tick(4);
        cs_n = 1'b1;
        t_cs = cyc;
        tick(16);
    endtask

    // mode-1 master: data changes on the rising edge, sampled on the falling edge
    task automatic send1(input logic [15:0] w);
        cs_n = 1'b0;
        tick(4);
        for (int i = 0; i < 16; i++) begin
            sclk = 1'b1;
            mosi = w[15-i];
            tick(4);
            sclk = 1'b0;
            tick(4);
        end
        tick(4);
        cs_n = 1'b1;
        tick(16);
    endtask

    initial begin
        rst = 1'b1; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1;
        tick(5);
        check("rst_word", word0, 0);
        check("rst_dv", dv0, 0);
        check("rst_err", err0, 0);
        check("rst_busy", busy0, 0);
        check("rst_errcnt", ecnt0, 0);
        rst = 1'b0;
        tick(10);

        send0(16'h9E23, 16, -1);
        check("t1_dv_count", dv0_cnt, 1);
        check("t1_word", words[0], 16'h9E23);
        check("t1_latency", last_dv_cyc - (t_cs + 1), 4);
        check("t1_no_err", err0_cnt, 0);

        send0(16'hFFFF, 16, -1);
        send0(16'h0000, 16, -1);
        send0(16'h8001, 16, -1);
        check("t2_dv_count", dv0_cnt, 4);
        check("t2_word_a", words[1], 16'hFFFF);
        check("t2_word_b", words[2], 16'h0000);
        check("t2_word_c", words[3], 16'h8001);
        check("t2_errcnt", ecnt0, 0);

        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(10);
        check("t3_word_cleared", word0, 0);
        send0(16'hFFFF, 15, -1);
        check("t3_short_err", err0_cnt, 1);
        check("t3_short_word", word0, 0);
        send0(16'h1234, 17, -1);
        check("t3_long_err", err0_cnt, 2);
        check("t3_long_word", word0, 0);
        check("t3_no_dv", dv0_cnt, 4);
        send0(16'h1234, 16, -1);
        check("t3_good_word", word0, 16'h1234);
        check("t3_good_dv", dv0_cnt, 5);
        check("t3_errcnt", ecnt0, 2);

        send0(16'h5555, 16, 8);
        check("t4_no_dv", dv0_cnt, 5);
        check("t4_no_err", err0_cnt, 2);
        check("t4_errcnt_cleared", ecnt0, 0);
        send0(16'hA5A5, 16, -1);
        check("t4_word", word0, 16'hA5A5);
        check("t4_dv", dv0_cnt, 6);

        for (int i = 0; i < 300; i++) begin
            cs_n = 1'b0;
            tick(4);
            cs_n = 1'b1;
            tick(6);
        end
        tick(10);
        check("t5_errcnt_sat", ecnt0, 255);
        check("t5_err_pulses", err0_cnt, 302);
        check("t5_word_held", word0, 16'hA5A5);
        check("t5_no_dv", dv0_cnt, 6);

        dv1_base = dv1_cnt;
        err1_base = err1_cnt;
        send1(16'h5AC3);
        check("t6_cpha1_word", word1, 16'h5AC3);
        check("t6_cpha1_dv", dv1_cnt - dv1_base, 1);
        send0(16'h5AC3, 16, -1);
        check("t6_mode_mismatch_word", word1, 16'hB586);
        check("t6_mode_mismatch_dv", dv1_cnt - dv1_base, 2);
        check("t6_mode_mismatch_no_err", err1_cnt - err1_base, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
